lz4_out_packer: RTL
===================

LZ4_OUT_PACKER -- requirements
Module: lz4_out_packer

Interface
REQ-001 SHALL provide: clk  in  1  single clock for all logic.
REQ-002 SHALL provide: rstN  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: start  in  1  one-cycle pulse that arms a new stream.
REQ-004 SHALL provide: compress_done  in  1  one-cycle pulse; encoder has written its final word.
REQ-005 SHALL provide: enc_empty  in  1  encoder output FIFO empty.
REQ-006 SHALL provide: enc_rd  out  1  encoder FIFO read strobe, driving the encoder out_en.
REQ-007 SHALL provide: enc_data  in  34  encoder word; [33:32] byte count (0 means 4, 1..3 literal); valid bytes LSB-first from [7:0].
REQ-008 SHALL provide: enc_valid  in  1  enc_data valid, exactly 1 cycle after enc_rd.
REQ-009 SHALL provide: m_data  out  32  packed stream word, byte0 at [7:0].
REQ-010 SHALL provide: m_keep  out  4  per-byte valid mask, contiguous from bit0.
REQ-011 SHALL provide: m_valid, m_last  out  1 each  word valid; final word of stream.
REQ-012 SHALL provide: m_ready  in  1  downstream accept.
REQ-013 SHALL provide: byte_cnt  out  32  total bytes accepted from encoder this stream.
REQ-014 SHALL provide: pack_done  out  1  one-cycle pulse after the final word transfers.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, TERM; IDLE->RUN on start; RUN->FLUSH when done latched, enc_empty=1 and no read in flight; FLUSH->TERM when residual <4 and output slot free; TERM->IDLE when last word transfers.
REQ-016 SHALL ignore start outside IDLE; start in IDLE clears byte_cnt, accumulator, done latch.
REQ-017 SHALL latch compress_done in RUN, including when it coincides with enc_valid.
REQ-018 SHALL assert enc_rd only in RUN with enc_empty=0, no read in flight, residual count <=3.
REQ-019 SHALL append incoming bytes at accumulator position residual; 56-bit accumulator, count 0..7, never overflows.
REQ-020 SHALL move the low 4 bytes to the output register whenever count>=4 and (m_valid=0 or m_ready=1), m_keep=4'b1111, m_last=0.
REQ-021 SHALL in TERM emit the residual (0..3 bytes) as one word with m_last=1 and m_keep of the residual; unused bytes 0; residual 0 gives m_keep=4'b0000.
REQ-022 SHALL hold m_data, m_keep, m_last stable while m_valid=1 and m_ready=0.
REQ-023 SHALL sustain one packed word per cycle when m_ready stays high and input words are 4-byte.
REQ-024 SHALL add the enc_valid byte count to byte_cnt in the same cycle the bytes are stored; wraps modulo 2^32.
REQ-025 SHALL assert pack_done the cycle after the m_last transfer, and return to IDLE.
REQ-026 SHALL drop enc_valid arriving in IDLE/TERM without counting.

Reset
REQ-027 SHALL on rstN low asynchronously force IDLE; enc_rd, m_valid, m_last, pack_done=0; m_data=0, m_keep=0, byte_cnt=0; accumulator and latches cleared.
REQ-028 SHALL on reset mid-stream discard all buffered bytes; next stream requires a new start.

Configuration
REQ-029 SHALL support macro LZ4_PACK_BSWAP_EN: defined -> m_data and m_keep byte-reversed (byte0 at [31:24], keep bit3 first); undefined -> LSB-first as REQ-009.

Verification
REQ-030 SHALL cover: start; three 4-byte words 0x03020100,0x07060504,0x0B0A0908; done; m_ready=1 -> three full words, then keep=0000 last=1, byte_cnt=12, pack_done.
REQ-031 SHALL cover: words with counts 3,2,3 (bytes 00..07) -> two full words 0x03020100, 0x07060504, then keep=0000 last word; byte_cnt=8.
REQ-032 SHALL cover: single 1-byte word 0xAA, done -> one word m_data=0x000000AA, keep=0001, last=1.
REQ-033 SHALL cover: m_ready low 10 cycles mid-stream -> m_data stable, enc_rd stops when residual >3, no byte loss.
REQ-034 SHALL cover: rstN low while count=5 -> all outputs reset same cycle; after start, byte_cnt from 0.
REQ-035 SHALL cover: compress_done coinciding with enc_valid of last word -> word counted and packed before TERM.

Source files
------------

// File: rtl/lz4_out_packer_if.sv
// lz4_out_packer_if: packed output word stream with valid/ready handshake.
// The master drives data, keep, valid and last; the slave returns ready.
interface lz4_out_packer_if;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  modport master (
    output m_data, m_keep, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_keep, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/lz4_out_packer.sv
// lz4_out_packer: repacks 1..4-byte encoder words into 32-bit stream words.
// Define LZ4_PACK_BSWAP_EN for MSB-first byte order on m_data/m_keep.
module lz4_out_packer (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic        compress_done,
  input  logic        enc_empty,
  output logic        enc_rd,
  input  logic [33:0] enc_data,
  input  logic        enc_valid,
  lz4_out_packer_if.master m,
  output logic [31:0] byte_cnt,
  output logic        pack_done
);

  typedef enum logic [1:0] {
    IDLE, RUN, FLUSH, TERM
  } state_t;

  state_t state, state_nxt;

  logic [55:0] acc, acc_all;
  logic [2:0]  cnt, n, add;
  logic [2:0]  total, nc;
  logic        done_q, rd_q;
  logic [31:0] dat_q, in_mask;
  logic [3:0]  keep_q, res_keep;
  logic        valid_q, last_q;
  logic        take, slot_free;
  logic        move, xfer, busy;

  always_comb begin
    n = (enc_data[33:32] == 2'd0) ? 3'd4
                                  : {1'b0, enc_data[33:32]};
    take = (state == RUN) && enc_valid;
    add = take ? n : 3'd0;
    in_mask = ~(32'hFFFF_FFFF << {n, 3'b000});
    acc_all = acc | ({24'd0, take ? (enc_data[31:0] & in_mask) : 32'd0}
                     << {cnt, 3'b000});
    total = cnt + add;
    slot_free = !valid_q || m.m_ready;
    busy = (state == RUN) || (state == FLUSH);
    move = busy && (total >= 3'd4) && slot_free;
    nc = move ? total - 3'd4 : total;
    // A read lands one cycle after its strobe, so back-to-back reads are safe.
    enc_rd = (state == RUN) && !enc_empty
          && !(rd_q && !enc_valid) && (nc <= 3'd3);
    xfer = valid_q && m.m_ready;
    res_keep = ~(4'hF << cnt);
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE:
        if (start) state_nxt = RUN;
      state == RUN:
        if (done_q && enc_empty && !rd_q) state_nxt = FLUSH;
      state == FLUSH:
        if ((cnt < 3'd4) && slot_free) state_nxt = TERM;
      default:
        if (xfer) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc       <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      dat_q     <= '0;
      keep_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      byte_cnt  <= '0;
      pack_done <= 1'b0;
    end else begin
      pack_done <= 1'b0;
      rd_q      <= enc_rd;
      if (xfer) valid_q <= 1'b0;
      unique case (1'b1)
        state == IDLE:
          if (start) begin
            acc      <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            byte_cnt <= '0;
          end
        state == TERM:
          if (xfer) begin
            last_q    <= 1'b0;
            pack_done <= 1'b1;
          end
        default: begin
          if (state == RUN) begin
            done_q   <= done_q | compress_done;
            byte_cnt <= byte_cnt + {29'd0, add};
          end
          if (state_nxt == TERM) begin
            dat_q   <= acc[31:0];
            keep_q  <= res_keep;
            last_q  <= 1'b1;
            valid_q <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
          end else begin
            if (move) begin
              dat_q   <= acc_all[31:0];
              keep_q  <= 4'hF;
              last_q  <= 1'b0;
              valid_q <= 1'b1;
              acc     <= acc_all >> 32;
            end else begin
              acc <= acc_all;
            end
            cnt <= nc;
          end
        end
      endcase
    end
  end

`ifdef LZ4_PACK_BSWAP_EN
  assign m.m_data = {dat_q[7:0], dat_q[15:8],
                     dat_q[23:16], dat_q[31:24]};
  assign m.m_keep = {keep_q[0], keep_q[1],
                     keep_q[2], keep_q[3]};
`else
  assign m.m_data = dat_q;
  assign m.m_keep = keep_q;
`endif
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;

endmodule
